// File: rtl/multicycle_controller.sv
// Sequencing FSM for a multicycle RV32I datapath that shares one memory port
// between instruction fetch and data access. Walks each instruction through
// fetch/decode/execute/writeback and drives the per-state datapath strobes.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// FETCH    | read instruction at PC, latch IR/OldPC, PC <= PC+4
// DECODE   | classify opcode, precompute branch target into ALU-out
// MEMADR   | rs1 + imm -> ALU-out (load/store address)
// MEMREAD  | read data memory at ALU-out address
// MEMWB    | write loaded data register into rd
// MEMWRITE | write rs2 to data memory at ALU-out address
// EXECUTER | rs1 op rs2
// EXECUTEI | rs1 op imm
// ALUWB    | write ALU-out register into rd
// BEQ      | compare rs1/rs2, take branch target when equal
// JAL      | PC <= target, OldPC+4 -> ALU-out for the link write
module multicycle_controller #(
  parameter bit WAIT_ON_MEM = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic       illegal_op,
  output logic       instr_done
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10
  } state_t;

  state_t state;
  state_t state_n;

  logic rdy;
  logic pcupdate;
  logic branch;

  // With the handshake disabled the memory is assumed single-cycle.
  assign rdy = mem_ready | ~WAIT_ON_MEM;

  // State register; reset parks the sequencer at FETCH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH;
    end else begin
      state <= state_n;
    end
  end

  // Immediate format follows the opcode directly so it is valid in DECODE.
  always_comb begin
    ImmSrc = 2'b00;
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  // Next-state and per-state control strobes.
  always_comb begin
    state_n    = state;
    pcupdate   = 1'b0;
    branch     = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUOp      = 2'b00;
    RegWrite   = 1'b0;
    illegal_op = 1'b0;
    instr_done = 1'b0;

    case (state)
      FETCH: begin
        AdrSrc    = 1'b0;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b10;
        ALUOp     = 2'b00;
        ResultSrc = 2'b10;
        IRWrite   = rdy;
        pcupdate  = rdy;
        if (rdy) begin
          state_n = DECODE;
        end
      end

      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b00;
        case (op)
          OP_LW, OP_SW: state_n = MEMADR;
          OP_R:         state_n = EXECUTER;
          OP_I:         state_n = EXECUTEI;
          OP_BEQ:       state_n = BEQ;
          OP_JAL:       state_n = JAL;
          default: begin
            state_n    = FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end

      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b00;
        if (op == OP_LW) begin
          state_n = MEMREAD;
        end else if (op == OP_SW) begin
          state_n = MEMWRITE;
        end else begin
          state_n = FETCH;
        end
      end

      MEMREAD: begin
        AdrSrc    = 1'b1;
        ResultSrc = 2'b00;
        if (rdy) begin
          state_n = MEMWB;
        end
      end

      MEMWB: begin
        ResultSrc  = 2'b01;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_n    = FETCH;
      end

      MEMWRITE: begin
        AdrSrc    = 1'b1;
        ResultSrc = 2'b00;
        MemWrite  = 1'b1;
        if (rdy) begin
          instr_done = 1'b1;
          state_n    = FETCH;
        end
      end

      EXECUTER: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b00;
        ALUOp   = 2'b10;
        state_n = ALUWB;
      end

      EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
        state_n = ALUWB;
      end

      ALUWB: begin
        ResultSrc  = 2'b00;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_n    = FETCH;
      end

      BEQ: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b00;
        ALUOp      = 2'b01;
        ResultSrc  = 2'b00;
        branch     = 1'b1;
        instr_done = 1'b1;
        state_n    = FETCH;
      end

      JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ALUOp     = 2'b00;
        ResultSrc = 2'b00;
        pcupdate  = 1'b1;
        state_n   = ALUWB;
      end

      default: begin
        state_n = FETCH;
      end
    endcase

    // Architectural strobes must not fire while reset is held, even though
    // the state register already reads FETCH.
    if (reset) begin
      pcupdate   = 1'b0;
      branch     = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      illegal_op = 1'b0;
      instr_done = 1'b0;
    end
  end

  assign PCWrite = (branch & zero) | pcupdate;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: each stimulus cycle pushes its
// hand-computed control vector into a queue; a monitor pops and compares on
// the falling edge of the same cycle.
module tb_multicycle_controller;

  logic       clk;
  logic       reset;
  logic [6:0] op;
  logic       zero;
  logic       mem_ready;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] ImmSrc;
  logic       RegWrite;
  logic       illegal_op;
  logic       instr_done;

  int total;
  int bad;
  int done_seen;
  int done_exp;

  string       name_q[$];
  logic [16:0] exp_q[$];

  multicycle_controller #(.WAIT_ON_MEM(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUOp      (ALUOp),
    .ImmSrc     (ImmSrc),
    .RegWrite   (RegWrite),
    .illegal_op (illegal_op),
    .instr_done (instr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUOp,ImmSrc,RegWrite,illegal_op,instr_done}
  function automatic logic [16:0] v(input logic pcw, input logic adr, input logic mw,
                                    input logic irw, input logic [1:0] rs,
                                    input logic [1:0] sa, input logic [1:0] sb,
                                    input logic [1:0] aop, input logic [1:0] imm,
                                    input logic rw, input logic ill, input logic dn);
    return {pcw, adr, mw, irw, rs, sa, sb, aop, imm, rw, ill, dn};
  endfunction

  function automatic logic [16:0] v_fetch(input logic [1:0] imm);
    return v(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b00, imm, 0, 0, 0);
  endfunction

  function automatic logic [16:0] v_decode(input logic [1:0] imm);
    return v(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, imm, 0, 0, 0);
  endfunction

  function automatic logic [16:0] v_memadr(input logic [1:0] imm);
    return v(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, imm, 0, 0, 0);
  endfunction

  function automatic logic [16:0] v_aluwb(input logic [1:0] imm);
    return v(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, imm, 1, 0, 1);
  endfunction

  // One clock cycle: apply inputs, queue the expected vector, advance.
  task automatic step(input logic rst, input logic mr, input logic z,
                      input string nm, input logic [16:0] e);
    reset     = rst;
    mem_ready = mr;
    zero      = z;
    name_q.push_back(nm);
    exp_q.push_back(e);
    if (e[0]) done_exp++;
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare DUT controls against the queued expectation.
  always @(negedge clk) begin
    logic [16:0] act;
    string       nm;
    logic [16:0] e;
    act = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUOp, ImmSrc, RegWrite, illegal_op, instr_done};
    if (instr_done) done_seen++;
    if (name_q.size() > 0) begin
      nm = name_q.pop_front();
      e  = exp_q.pop_front();
      total++;
      if (act !== e) begin
        bad++;
        $display("FAIL %s: got %b want %b", nm, act, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    total     = 0;
    bad       = 0;
    done_seen = 0;
    done_exp  = 0;
    reset     = 1'b1;
    op        = 7'b0000000;
    zero      = 1'b0;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;

    // Reset held: FETCH decode visible but strobes forced low.
    step(1, 1, 0, "reset_state", v(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 0, 0, 0));

    // R-type, 4 cycles.
    op = 7'b0110011;
    step(0, 1, 0, "r_fetch",    v_fetch(2'b00));
    step(0, 1, 0, "r_decode",   v_decode(2'b00));
    step(0, 1, 0, "r_executer", v(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0, 0));
    step(0, 1, 0, "r_aluwb",    v_aluwb(2'b00));

    // I-type ALU with one FETCH stall.
    op = 7'b0010011;
    step(0, 0, 0, "i_fetch_stall", v(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 0, 0, 0));
    step(0, 1, 0, "i_fetch",       v_fetch(2'b00));
    step(0, 1, 0, "i_decode",      v_decode(2'b00));
    step(0, 1, 0, "i_executei",    v(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10, 2'b00, 0, 0, 0));
    step(0, 1, 0, "i_aluwb",       v_aluwb(2'b00));

    // lw with two MEMREAD stalls: 7 cycles.
    op = 7'b0000011;
    step(0, 1, 0, "lw_fetch",    v_fetch(2'b00));
    step(0, 1, 0, "lw_decode",   v_decode(2'b00));
    step(0, 1, 0, "lw_memadr",   v_memadr(2'b00));
    step(0, 0, 0, "lw_memread0", v(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0));
    step(0, 0, 0, "lw_memread1", v(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0));
    step(0, 1, 0, "lw_memread2", v(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0));
    step(0, 1, 0, "lw_memwb",    v(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 1));

    // sw with one MEMWRITE stall: MemWrite two cycles, done on the second.
    op = 7'b0100011;
    step(0, 1, 0, "sw_fetch",     v_fetch(2'b01));
    step(0, 1, 0, "sw_decode",    v_decode(2'b01));
    step(0, 1, 0, "sw_memadr",    v_memadr(2'b01));
    step(0, 0, 0, "sw_memwrite0", v(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 0, 0, 0));
    step(0, 1, 0, "sw_memwrite1", v(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 0, 0, 1));

    // beq taken then not taken.
    op = 7'b1100011;
    step(0, 1, 1, "beqt_fetch",  v_fetch(2'b10));
    step(0, 1, 1, "beqt_decode", v_decode(2'b10));
    step(0, 1, 1, "beqt_beq",    v(1, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 2'b10, 0, 0, 1));
    step(0, 1, 0, "beqn_fetch",  v_fetch(2'b10));
    step(0, 1, 0, "beqn_decode", v_decode(2'b10));
    step(0, 1, 0, "beqn_beq",    v(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 2'b10, 0, 0, 1));

    // Illegal opcode: 2 cycles, no architectural write.
    op = 7'b1111111;
    step(0, 1, 0, "ill_fetch",  v_fetch(2'b00));
    step(0, 1, 0, "ill_decode", v(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 0, 1, 0));

    // jal: PCWrite in JAL, link write and done in ALUWB.
    op = 7'b1101111;
    step(0, 1, 0, "jal_fetch",  v_fetch(2'b11));
    step(0, 1, 0, "jal_decode", v_decode(2'b11));
    step(0, 1, 0, "jal_jal",    v(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 2'b11, 0, 0, 0));
    step(0, 1, 0, "jal_aluwb",  v_aluwb(2'b11));

    // Async reset inside a MEMWRITE stall.
    op = 7'b0100011;
    step(0, 1, 0, "swr_fetch",     v_fetch(2'b01));
    step(0, 1, 0, "swr_decode",    v_decode(2'b01));
    step(0, 1, 0, "swr_memadr",    v_memadr(2'b01));
    step(0, 0, 0, "swr_memwrite0", v(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 0, 0, 0));
    // Reset rises mid-cycle while still stalled in MEMWRITE.
    step(1, 0, 0, "swr_reset_now", v(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b01, 0, 0, 0));
    step(0, 1, 0, "swr_post_fetch", v_fetch(2'b01));
    step(0, 1, 0, "swr_post_decode", v_decode(2'b01));

    @(negedge clk);
    #1;
    total++;
    if (done_seen != done_exp) begin
      bad++;
      $display("FAIL done_count: got %0d want %0d", done_seen, done_exp);
    end
    total++;
    if (name_q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain: got %0d want 0", name_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
